// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// mux-select values and the packed control word driven onto the datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_JR       = 4'd11,
    S_IMM_EX   = 4'd12,
    S_IMM_WB   = 4'd13
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_ALUOUT = 2'd2;
  localparam logic [1:0] PC_A      = 2'd3;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_SE   = 2'd2;
  localparam logic [1:0] SRCB_SESH = 2'd3;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_SLTI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state(+opCode) -> datapath control word; zero-latency.
// Only IMM_EX (ALUOp) and DECODE (illegal flag) look at the opcode.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_4;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_src    = PC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_SESH;
        o_ctrl.alu_op    = ALU_ADD;
        o_illegal        = !op_is_legal(i_op);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_SE;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RT;
        o_ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEMWRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_RTYPE_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FN;
      end
      S_RTYPE_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RD;
        o_ctrl.mem_to_reg = M2R_ALU;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.pc_cond   = 1'b1;
        o_ctrl.pc_src    = PC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PC_JUMP;
      end
      // PC already holds PC+4, so r31 captures the return address on the redirect edge.
      S_JAL: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_src     = PC_JUMP;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_R31;
        o_ctrl.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PC_A;
      end
      S_IMM_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_SE;
        o_ctrl.alu_op    = (i_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IMM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RT;
        o_ctrl.mem_to_reg = M2R_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multi-cycle MIPS datapath, one state per cycle.
// Outputs are held at zero for as long as rst is low; FETCH runs on the first edge after release.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  input  logic [5:0] funct,
  output logic       pcWrite,
  output logic       pcConditional,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] regDst,
  output logic [1:0] memtoreg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;
  logic   w_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (opCode)
          OP_RTYPE:     w_next = (funct == FN_JR) ? S_JR : S_RTYPE_EX;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_JAL:       w_next = S_JAL;
          OP_ADDI,
          OP_SLTI:      w_next = S_IMM_EX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opCode == OP_LW)      w_next = S_MEMREAD;
        else if (opCode == OP_SW) w_next = S_MEMWRITE;
        else                      w_next = S_FETCH;
      end
      S_MEMREAD:  w_next = S_MEMWB;
      S_RTYPE_EX: w_next = S_RTYPE_WB;
      S_IMM_EX:   w_next = S_IMM_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  ctrl_decode u_decode (
    .i_state   (r_state),
    .i_op      (opCode),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  assign w_out         = rst ? w_ctrl : '0;
  assign pcWrite       = w_out.pc_write;
  assign pcConditional = w_out.pc_cond;
  assign IorD          = w_out.i_or_d;
  assign memRead       = w_out.mem_read;
  assign memWrite      = w_out.mem_write;
  assign IRWrite       = w_out.ir_write;
  assign regWrite      = w_out.reg_write;
  assign ALUSrcA       = w_out.alu_src_a;
  assign regDst        = w_out.reg_dst;
  assign memtoreg      = w_out.mem_to_reg;
  assign ALUSrcB       = w_out.alu_src_b;
  assign ALUOp         = w_out.alu_op;
  assign PCSrc         = w_out.pc_src;
  assign illegal_op    = rst & w_illegal;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver pushes per-cycle expectations from an instruction-level model,
// the monitor pops and compares one entry every cycle the controller is out of reset.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcc, iord, mr, mw, irw, rw, asa;
    logic [1:0] rd, m2r, asb, aop, pcs;
    logic ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opCode, funct;
  logic pcWrite, pcConditional, IorD, memRead, memWrite, IRWrite, regWrite, ALUSrcA;
  logic [1:0] regDst, memtoreg, ALUSrcB, ALUOp, PCSrc;
  logic illegal_op;
  logic [3:0] state;

  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct(funct),
    .pcWrite(pcWrite), .pcConditional(pcConditional), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
    .regWrite(regWrite), .ALUSrcA(ALUSrcA), .regDst(regDst),
    .memtoreg(memtoreg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .state(state)
  );

  function automatic exp_t act_vec();
    return {state, pcWrite, pcConditional, IorD, memRead, memWrite, IRWrite,
            regWrite, ALUSrcA, regDst, memtoreg, ALUSrcB, ALUOp, PCSrc, illegal_op};
  endfunction

  // Instruction length in cycles from the CPI table.
  function automatic int inst_len(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b001000, 6'b001010: return 4;
      6'b000000: return (fn == 6'b001000) ? 3 : 4;
      6'b000100, 6'b000010, 6'b000011: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = FETCH) of the instruction {op, fn}.
  function automatic exp_t exp_of(input logic [5:0] op, input logic [5:0] fn, input int k);
    exp_t e;
    e = '0;
    if (k == 0) begin
      e.st = S_FETCH; e.mr = 1; e.irw = 1; e.pcw = 1; e.asb = 2'd1;
    end else if (k == 1) begin
      e.st = S_DECODE; e.asb = 2'd3; e.ill = (inst_len(op, fn) == 2);
    end else begin
      case (op)
        6'b100011, 6'b101011: begin
          if (k == 2) begin e.st = S_MEMADR; e.asa = 1; e.asb = 2'd2; end
          else if (op == 6'b101011) begin e.st = S_MEMWRITE; e.mw = 1; e.iord = 1; end
          else if (k == 3) begin e.st = S_MEMREAD; e.mr = 1; e.iord = 1; end
          else begin e.st = S_MEMWB; e.rw = 1; e.m2r = 2'd1; end
        end
        6'b000000: begin
          if (fn == 6'b001000) begin e.st = S_JR; e.pcw = 1; e.pcs = 2'd3; end
          else if (k == 2) begin e.st = S_RTYPE_EX; e.asa = 1; e.aop = 2'b10; end
          else begin e.st = S_RTYPE_WB; e.rw = 1; e.rd = 2'd1; end
        end
        6'b000100: begin e.st = S_BRANCH; e.asa = 1; e.aop = 2'b01; e.pcc = 1; e.pcs = 2'd2; end
        6'b000010: begin e.st = S_JUMP; e.pcw = 1; e.pcs = 2'd1; end
        6'b000011: begin
          e.st = S_JAL; e.pcw = 1; e.pcs = 2'd1; e.rw = 1; e.rd = 2'd2; e.m2r = 2'd2;
        end
        default: begin
          if (k == 2) begin
            e.st = S_IMM_EX; e.asa = 1; e.asb = 2'd2;
            e.aop = (op == 6'b001010) ? 2'b11 : 2'b00;
          end else begin
            e.st = S_IMM_WB; e.rw = 1;
          end
        end
      endcase
    end
    return e;
  endfunction

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%h expected=%h (state act=%0d exp=%0d)",
               nm, $time, act, exp, act.st, exp.st);
    end
  endtask

  task automatic run_inst(input logic [5:0] op, input logic [5:0] fn);
    int n;
    opCode = op;
    funct  = fn;
    n = inst_len(op, fn);
    for (int k = 0; k < n; k++) q.push_back(exp_of(op, fn, k));
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every cycle either the reset-forced zero word or the next scoreboard entry.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (!rst) begin
        check("reset_zero", act_vec(), '0);
      end else if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL underflow t=%0t actual=%h expected=<none>", $time, act_vec());
      end else begin
        e = q.pop_front();
        check("step", act_vec(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op, fn;
    int sel;
    rst = 1'b0; opCode = 6'd0; funct = 6'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_inst(6'b100011, 6'b000100);
    run_inst(6'b101011, 6'b000000);
    run_inst(6'b000000, 6'b100000);
    run_inst(6'b000000, 6'b001000);
    run_inst(6'b000011, 6'b000000);
    run_inst(6'b001010, 6'b000000);
    run_inst(6'b001000, 6'b000000);
    run_inst(6'b111111, 6'b000000);
    run_inst(6'b000100, 6'b000000);
    run_inst(6'b000010, 6'b000000);

    // Reset asserted while lw sits in MEMREAD: no MEMWB may follow release.
    opCode = 6'b100011; funct = 6'd0;
    for (int k = 0; k < 4; k++) q.push_back(exp_of(6'b100011, 6'd0, k));
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    rst = 1'b0;
    #1 check("rst_immediate", act_vec(), '0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_inst(6'b001000, 6'b000000);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      fn  = 6'($urandom);
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: begin op = 6'b000000; fn = 6'b001000; end
        4: op = 6'b000100;
        5: op = 6'b000010;
        6: op = 6'b000011;
        7: op = 6'b001000;
        8: op = 6'b001010;
        default: op = 6'($urandom);
      endcase
      run_inst(op, fn);
    end

    done = 1'b1;
    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d entries expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
